// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: PC, register file, instruction and data memory.
// Ports: clk (rising edge), reset (synchronous, active-high). No other pins.

module rv32i_regfile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] regFile [0:31];

    // x0 is hard-wired: reads give zero and writes are dropped.
    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regFile[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regFile[ra2_i];

    always_ff @(posedge clk_i) begin
        if (we_i && wa_i != 5'd0)
            regFile[wa_i] <= wd_i;
    end
endmodule

module rv32i_imem #(
    parameter int MEM_WORDS = 1024,
    parameter int AW = $clog2(MEM_WORDS)
) (
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   data_o
);
    logic [31:0] mem [0:MEM_WORDS-1];

    assign data_o = mem[addr_i];
endmodule

module rv32i_dmem #(
    parameter int MEM_WORDS = 1024,
    parameter int AW = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wd_i,
    output logic [31:0]   rd_o
);
    logic [31:0] mem [0:MEM_WORDS-1];

    assign rd_o = mem[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i)
            mem[addr_i] <= wd_i;
    end
endmodule

module rv32i_core #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic reset
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] pc;
    logic [31:0] pc_in;
    logic [31:0] instruction_mux_out;
    logic [31:0] mux_a_out;
    logic [31:0] mux_b_out;
    logic [31:0] alu_out;
    logic [31:0] imem_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] dmem_data;
    logic [31:0] imm;
    logic [31:0] wb_data;
    logic [31:0] pc_plus4;
    logic        rf_we;
    logic        dm_we;
    logic        br_taken;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_lui, is_auipc, is_jal;
    logic       is_jalr, is_br, is_lw, is_sw;

    rv32i_imem #(.MEM_WORDS(MEM_WORDS)) insn_memory (
        .addr_i (pc[AW+1:2]),
        .data_o (imem_data)
    );

    // Reset forces a NOP so nothing retires while held.
    assign instruction_mux_out = reset ? 32'h0000_0013 : imem_data;

    assign opcode   = instruction_mux_out[6:0];
    assign funct3   = instruction_mux_out[14:12];
    assign is_r     = (opcode == 7'b0110011);
    assign is_i     = (opcode == 7'b0010011);
    assign is_lui   = (opcode == 7'b0110111);
    assign is_auipc = (opcode == 7'b0010111);
    assign is_jal   = (opcode == 7'b1101111);
    assign is_jalr  = (opcode == 7'b1100111);
    assign is_br    = (opcode == 7'b1100011);
    assign is_lw    = (opcode == 7'b0000011);
    assign is_sw    = (opcode == 7'b0100011);

    rv32i_regfile register_file (
        .clk_i (clk),
        .we_i  (rf_we),
        .ra1_i (instruction_mux_out[19:15]),
        .ra2_i (instruction_mux_out[24:20]),
        .wa_i  (instruction_mux_out[11:7]),
        .wd_i  (wb_data),
        .rd1_o (rs1_data),
        .rd2_o (rs2_data)
    );

    always_comb begin
        logic [31:0] i;
        i   = instruction_mux_out;
        imm = {{20{i[31]}}, i[31:20]};
        if (is_sw)
            imm = {{20{i[31]}}, i[31:25], i[11:7]};
        else if (is_br)
            imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        else if (is_lui || is_auipc)
            imm = {i[31:12], 12'd0};
        else if (is_jal)
            imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    end

    // Operand A is the PC for every PC-relative target.
    assign mux_a_out = (is_auipc || is_jal || is_br) ? pc : rs1_data;
    assign mux_b_out = is_r ? rs2_data : imm;

    always_comb begin
        alu_out = mux_a_out + mux_b_out;
        if (is_r || is_i) begin
            case (funct3)
                3'b000: if (is_r && instruction_mux_out[30])
                            alu_out = mux_a_out - mux_b_out;
                3'b001: alu_out = mux_a_out << mux_b_out[4:0];
                3'b010: alu_out = {31'd0, $signed(mux_a_out) < $signed(mux_b_out)};
                3'b011: alu_out = {31'd0, mux_a_out < mux_b_out};
                3'b100: alu_out = mux_a_out ^ mux_b_out;
                3'b101: alu_out = instruction_mux_out[30]
                            ? 32'($signed(mux_a_out) >>> mux_b_out[4:0])
                            : mux_a_out >> mux_b_out[4:0];
                3'b110: alu_out = mux_a_out | mux_b_out;
                default: alu_out = mux_a_out & mux_b_out;
            endcase
        end else if (is_lui) begin
            alu_out = mux_b_out;
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs1_data == rs2_data);
            3'b001:  br_taken = (rs1_data != rs2_data);
            3'b100:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
            3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_taken = (rs1_data < rs2_data);
            3'b111:  br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_in = pc_plus4;
        if (is_jal || (is_br && br_taken))
            pc_in = alu_out;
        else if (is_jalr)
            pc_in = alu_out & ~32'd1;
    end

    rv32i_dmem #(.MEM_WORDS(MEM_WORDS)) data_memory (
        .clk_i  (clk),
        .we_i   (dm_we),
        .addr_i (alu_out[AW+1:2]),
        .wd_i   (rs2_data),
        .rd_o   (dmem_data)
    );

    assign rf_we = !reset && (is_r || is_i || is_lui || is_auipc ||
                              is_jal || is_jalr || is_lw);
    assign dm_we = !reset && is_sw;

    always_comb begin
        wb_data = alu_out;
        if (is_jal || is_jalr)
            wb_data = pc_plus4;
        else if (is_lw)
            wb_data = dmem_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else
            pc <= pc_in;
    end
endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: preloads memories, runs short programs,
// and checks PC, registers and data memory against a scoreboard queue.

module tb_rv32i_core;
    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          kind;  // 0 pc, 1 reg, 2 dmem, 3 instruction
        int          idx;
        logic [31:0] exp;
        string       tag;
    } item_t;

    item_t sb[$];

    rv32i_core dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
        input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
    endfunction

    task automatic push(input int kind, input int idx, input logic [31:0] exp,
                        input string tag);
        item_t it;
        it.kind = kind;
        it.idx  = idx;
        it.exp  = exp;
        it.tag  = tag;
        sb.push_back(it);
    endtask

    task automatic drain();
        item_t       it;
        logic [31:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.kind)
                0:       act = dut.pc;
                1:       act = dut.register_file.regFile[it.idx];
                2:       act = dut.data_memory.mem[it.idx];
                default: act = dut.instruction_mux_out;
            endcase
            total++;
            assert (act === it.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", it.tag, act, it.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_prog();
        for (int k = 0; k < 1024; k++)
            dut.insn_memory.mem[k] = 32'd0;
    endtask

    task automatic load_regs();
        for (int k = 0; k < 32; k++)
            dut.register_file.regFile[k] = k;
    endtask

    // Hold reset for one edge so preload happens while writes are blocked.
    task automatic restart();
        reset = 1'b1;
        step(1);
        push(0, 0, 32'd0, "reset_pc");
        push(3, 0, 32'h13, "reset_nop");
        drain();
        clear_prog();
        load_regs();
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 1024; k++)
            dut.data_memory.mem[k] = 32'd0;
        clear_prog();
        load_regs();
        step(1);

        // Basic ALU sequence
        restart();
        dut.insn_memory.mem[0] = enc_i(12'd42, 5'd1, 3'd0, 5'd1, 7'h13);
        dut.insn_memory.mem[1] = enc_i(12'd53, 5'd2, 3'd0, 5'd2, 7'h13);
        dut.insn_memory.mem[2] = enc_r(7'd0, 5'd2, 5'd1, 3'd4, 5'd3);
        reset = 1'b0;
        step(3);
        push(1, 1, 32'd43, "addi_x1");
        push(1, 2, 32'd55, "addi_x2");
        push(1, 3, 32'd28, "xor_x3");
        push(0, 0, 32'd12, "pc_after3");
        drain();

        // Reset in the middle of the program
        restart();
        dut.insn_memory.mem[0] = enc_i(12'd42, 5'd1, 3'd0, 5'd1, 7'h13);
        dut.insn_memory.mem[1] = enc_i(12'd53, 5'd2, 3'd0, 5'd2, 7'h13);
        dut.insn_memory.mem[2] = enc_r(7'd0, 5'd2, 5'd1, 3'd4, 5'd3);
        reset = 1'b0;
        step(2);
        push(0, 0, 32'd8, "mid_pc8");
        drain();
        reset = 1'b1;
        step(1);
        push(0, 0, 32'd0, "mid_reset_pc");
        push(1, 3, 32'd3, "mid_reset_x3");
        push(1, 1, 32'd43, "mid_reset_x1");
        drain();
        reset = 1'b0;
        step(1);
        push(0, 0, 32'd4, "restart_pc");
        push(1, 1, 32'd85, "restart_x1");
        drain();

        // Store / load / x0
        restart();
        dut.insn_memory.mem[0] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd5, 7'h13);
        dut.insn_memory.mem[1] = enc_s(12'd16, 5'd5, 5'd0);
        dut.insn_memory.mem[2] = enc_i(12'd16, 5'd0, 3'd2, 5'd6, 7'h03);
        dut.insn_memory.mem[3] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13);
        reset = 1'b0;
        step(4);
        push(2, 4, 32'hFFFF_FFFF, "sw_mem4");
        push(1, 6, 32'hFFFF_FFFF, "lw_x6");
        push(1, 5, 32'hFFFF_FFFF, "addi_neg_x5");
        push(1, 0, 32'd0, "x0_zero");
        push(0, 0, 32'd16, "ldst_pc");
        drain();

        // Branches
        restart();
        dut.insn_memory.mem[0] = enc_b(13'd8, 5'd2, 5'd1, 3'd1);
        dut.insn_memory.mem[1] = enc_i(12'd99, 5'd0, 3'd0, 5'd7, 7'h13);
        dut.insn_memory.mem[2] = enc_b(-13'sd4, 5'd1, 5'd1, 3'd0);
        reset = 1'b0;
        step(1);
        push(0, 0, 32'd8, "bne_taken_pc");
        drain();
        step(1);
        push(0, 0, 32'd4, "beq_back_pc");
        push(1, 7, 32'd7, "skipped_x7");
        drain();
        step(1);
        push(1, 7, 32'd99, "after_loop_x7");
        push(0, 0, 32'd8, "after_loop_pc");
        drain();

        // Jumps
        restart();
        dut.insn_memory.mem[0] = enc_j(21'd12, 5'd1);
        dut.insn_memory.mem[3] = enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'h67);
        reset = 1'b0;
        step(1);
        push(1, 1, 32'd4, "jal_link");
        push(0, 0, 32'd12, "jal_pc");
        drain();
        step(1);
        push(0, 0, 32'd4, "jalr_pc");
        drain();

        // Wider ALU and branch coverage
        restart();
        dut.insn_memory.mem[0]  = {20'h80000, 5'd10, 7'h37};
        dut.insn_memory.mem[1]  = enc_i(12'h404, 5'd10, 3'd5, 5'd11, 7'h13);
        dut.insn_memory.mem[2]  = enc_i(12'h004, 5'd10, 3'd5, 5'd12, 7'h13);
        dut.insn_memory.mem[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd13);
        dut.insn_memory.mem[4]  = enc_r(7'd0, 5'd1, 5'd13, 3'd2, 5'd14);
        dut.insn_memory.mem[5]  = enc_r(7'd0, 5'd1, 5'd13, 3'd3, 5'd15);
        dut.insn_memory.mem[6]  = {20'h00001, 5'd16, 7'h17};
        dut.insn_memory.mem[7]  = enc_b(13'd8, 5'd1, 5'd13, 3'd4);
        dut.insn_memory.mem[8]  = enc_i(12'd1, 5'd0, 3'd0, 5'd17, 7'h13);
        dut.insn_memory.mem[9]  = enc_b(13'd8, 5'd1, 5'd13, 3'd7);
        dut.insn_memory.mem[10] = enc_i(12'd1, 5'd0, 3'd0, 5'd18, 7'h13);
        dut.insn_memory.mem[11] = enc_r(7'd0, 5'd4, 5'd2, 3'd1, 5'd19);
        reset = 1'b0;
        step(10);
        push(1, 10, 32'h8000_0000, "lui");
        push(1, 11, 32'hF800_0000, "srai");
        push(1, 12, 32'h0800_0000, "srli");
        push(1, 13, 32'hFFFF_FFFF, "sub");
        push(1, 14, 32'd1, "slt");
        push(1, 15, 32'd0, "sltu");
        push(1, 16, 32'h0000_1018, "auipc");
        push(1, 17, 32'd17, "blt_skip");
        push(1, 18, 32'd18, "bgeu_skip");
        push(1, 19, 32'd32, "sll");
        push(0, 0, 32'd48, "alu_pc");
        drain();

        // All-zero words behave as NOPs
        restart();
        reset = 1'b0;
        step(4);
        push(0, 0, 32'd16, "zero_pc");
        push(1, 1, 32'd1, "zero_x1");
        push(1, 31, 32'd31, "zero_x31");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Single-cycle RV32I integer core: every instruction is fetched, decoded, executed and retired in one clock.
- Contains the PC, a 32x32 register file, a 1024-word instruction memory and a 1024-word data memory.
- Top-level block with only clock and reset pins. Benches preload memories and registers hierarchically.

Parameters:
- MEM_WORDS, 1024, depth in 32-bit words of both instruction and data memory.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.

Behaviour:
- Required hierarchical names, which benches probe:
  - pc (32-bit register) and pc_in (next-PC, combinational).
  - instruction_mux_out, the instruction being executed.
  - mux_a_out and mux_b_out, the ALU operands.
  - alu_out.
  - register_file.regFile[0:31].
  - insn_memory.mem[0:1023] and data_memory.mem[0:1023].
- Reset:
  - At a rising edge with reset=1: pc<=RESET_PC, and no register-file or data-memory write occurs.
  - While reset=1, instruction_mux_out = 32'h0000_0013 (NOP).
  - The register file and memories are NOT cleared by reset, so preloaded contents survive.
- Fetch:
  - instruction_mux_out = insn_memory.mem[pc[11:2]] when reset=0. Combinational read.
  - pc[1:0] is ignored.
- Register file:
  - Two combinational read ports and one write port, written on the rising edge when the write-enable is set.
  - x0 always reads 0; writes to x0 are discarded.
- Supported instructions:
  - R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type ALU: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LW, SW.
- Immediates are sign-extended per the RV32I I/S/B/U/J formats. Shifts use the low 5 bits of the operand.
- Operand muxes:
  - mux_a_out is rs1, or pc for AUIPC/JAL/branch-target computation.
  - mux_b_out is rs2 or the immediate.
- Arithmetic is 32-bit and wraps; there is no overflow trap.
- Next PC (pc_in):
  - pc+4 by default.
  - Branch taken: pc+B-imm.
  - JAL: pc+J-imm.
  - JALR: (rs1+I-imm) & ~1.
  - JAL and JALR write pc+4 to rd.
- Loads and stores:
  - Effective address = rs1+imm; the word index is addr[11:2].
  - LW reads data_memory combinationally and writes rd at the edge.
  - SW writes rs2 to data_memory at the rising edge.
  - Only word access is supported; addr[1:0] is ignored and addresses wrap modulo MEM_WORDS.
- Any unrecognised opcode (including the all-zero word) executes as a NOP: no writes, pc<=pc+4.
- Each non-reset rising edge retires exactly one instruction, with latency of 1 cycle. An instruction that reads a register written by the previous instruction sees the new value.

Test Plan:
- Preload regFile[k]=k and mem[0..2] = ADDI x1,x1,42 / ADDI x2,x2,53 / XOR x3,x1,x2. Assert reset, release it, clock 3 cycles -> x1=43, x2=55, x3=28, pc=12.
- Reset mid-program: assert reset at pc=8 for one edge -> pc=0; no register change that cycle; execution restarts at mem[0].
- Store/load, with x1=1:
  - ADDI x5,x0,-1; SW x5,16(x0); LW x6,16(x0) -> data_memory.mem[4]=32'hFFFF_FFFF, x6=32'hFFFF_FFFF.
  - ADDI x0,x0,5 -> x0 stays 0.
- Branch: x1=1, x2=2 run through BNE x1,x2,+8 -> pc advances by 8, skipped instruction has no effect. BEQ x1,x1,-4 -> pc decreases by 4.
- Jumps: JAL x1,+12 at pc=0 -> x1=4, pc=12. JALR x0,0(x1) -> pc=4.
- All-zero instruction words -> pc increments by 4 per cycle and the register file is unchanged.
